// File: rtl/sm1118_adc_sensor_scheduler.sv
// rtl/sm1118_adc_sensor_scheduler.sv - round-robin ADC128S022 sequencer for the left/center/right line sensors
module sm1118_adc_sensor_scheduler #(
  parameter logic [2:0]  CH_LEFT    = 3'd5,
  parameter logic [2:0]  CH_CENTER  = 3'd6,
  parameter logic [2:0]  CH_RIGHT   = 3'd7,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        adc_dout,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_din,
  output logic [11:0] left_value,
  output logic [11:0] center_value,
  output logic [11:0] right_value,
  output logic        sweep_valid
);

  typedef enum logic {
    ST_GAP   = 1'b0,
    ST_FRAME = 1'b1
  } state_t;

  localparam logic [1:0] SLOT_L = 2'd0;
  localparam logic [1:0] SLOT_C = 2'd1;
  localparam logic [1:0] SLOT_R = 2'd2;
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  gap_cnt_q;
  logic [4:0]  cyc_q;       // clk count inside the frame, 0..31
  logic [1:0]  slot_q;      // slot whose data the running frame returns
  logic        primed_q;
  logic [2:0]  addr_q;      // address shifted out during the running frame
  logic [11:0] shift_q;
  logic        cs_n_q;
  logic        sclk_q;
  logic        din_q;
  logic [11:0] left_q;
  logic [11:0] center_q;
  logic [11:0] right_q;
  logic        sweep_q;

  logic [1:0]  next_slot_d;
  logic [2:0]  frame_addr_d;
  logic [4:0]  cyc_d;
  logic        gap_done_d;

  // Channel wired to a slot.
  function automatic logic [2:0] slot_ch(input logic [1:0] s);
    case (s)
      SLOT_L:  return CH_LEFT;
      SLOT_C:  return CH_CENTER;
      default: return CH_RIGHT;
    endcase
  endfunction

  // DIN value for bit index b of a frame carrying address a (ADD[2:0] on bits 2..4).
  function automatic logic din_bit(input logic [3:0] b, input logic [2:0] a);
    case (b)
      4'd2:    return a[2];
      4'd3:    return a[1];
      4'd4:    return a[0];
      default: return 1'b0;
    endcase
  endfunction

  // Next slot, address for the upcoming frame (ADC answers one frame late) and frame clk counter.
  always_comb begin
    next_slot_d  = (slot_q == SLOT_R) ? SLOT_L : slot_q + 2'd1;
    frame_addr_d = primed_q ? slot_ch(next_slot_d) : CH_LEFT;
    cyc_d        = cyc_q + 5'd1;
  end

  assign gap_done_d = (gap_cnt_q == GAP_LAST);

  // Frame sequencer: gap timing, SCLK/DIN generation, DOUT capture and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_GAP;
      gap_cnt_q <= 4'd0;
      cyc_q     <= 5'd0;
      slot_q    <= SLOT_L;
      primed_q  <= 1'b0;
      addr_q    <= 3'd0;
      shift_q   <= 12'd0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      din_q     <= 1'b0;
      left_q    <= 12'd0;
      center_q  <= 12'd0;
      right_q   <= 12'd0;
      sweep_q   <= 1'b0;
    end else begin
      sweep_q <= 1'b0;
      case (state_q)
        ST_GAP: begin
          if (!gap_done_d) begin
            gap_cnt_q <= gap_cnt_q + 4'd1;
          end else if (en) begin
            // Frame edge 0: CS and SCLK fall together, DIN carries bit 0.
            state_q <= ST_FRAME;
            cyc_q   <= 5'd0;
            cs_n_q  <= 1'b0;
            sclk_q  <= 1'b0;
            din_q   <= din_bit(4'd0, frame_addr_d);
            addr_q  <= frame_addr_d;
          end
        end
        default: begin
          if (cyc_q == 5'd31) begin
            // Edge after bit 15 was sampled: close the frame and publish the word.
            state_q   <= ST_GAP;
            gap_cnt_q <= 4'd0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b1;
            din_q     <= 1'b0;
            primed_q  <= 1'b1;
            if (primed_q) begin
              case (slot_q)
                SLOT_L:  left_q   <= shift_q;
                SLOT_C:  center_q <= shift_q;
                default: begin
                  right_q <= shift_q;
                  sweep_q <= 1'b1;
                end
              endcase
              slot_q <= next_slot_d;
            end
          end else begin
            cyc_q <= cyc_d;
            if (!cyc_q[0]) begin
              // Odd edge: SCLK rises, sample DOUT; the first four bits are leading zeros.
              sclk_q <= 1'b1;
              if (cyc_q[4:1] >= 4'd4) begin
                shift_q <= {shift_q[10:0], adc_dout};
              end
            end else begin
              // Even edge: SCLK falls, present the next DIN bit.
              sclk_q <= 1'b0;
              din_q  <= din_bit(cyc_d[4:1], addr_q);
            end
          end
        end
      endcase
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_sclk     = sclk_q;
  assign adc_din      = din_q;
  assign left_value   = left_q;
  assign center_value = center_q;
  assign right_value  = right_q;
  assign sweep_valid  = sweep_q;

endmodule
